// File: rtl/tt_um_noritsuna_inv_probe.sv
// Stimulus-and-measure probe for the analog inverter tile: toggles the inverter
// input, waits for the sensed output to follow, and reports rise/fall delays in cycles.
module tt_um_noritsuna_inv_probe #(
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    RISE   = 3'd2,
    FALL   = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] resp_sync_q, resp_sync_d;
  logic [SYNC_STAGES-1:0] start_sync_q, start_sync_d;
  logic                   start_prev_q, start_prev_d;
  logic                   invert_q, invert_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [7:0]             rise_dly_q, rise_dly_d;
  logic [7:0]             fall_dly_q, fall_dly_d;
  logic                   pass_q, pass_d;
  logic                   err_settle_q, err_settle_d;
  logic                   err_rise_q, err_rise_d;
  logic                   err_fall_q, err_fall_d;
  logic                   stim_q, stim_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic resp_s, start_s, start_edge_s, match_s, timeout_s;
  logic unused_s;

  // Level the DUT output must reach for a given stimulus level.
  function automatic logic expected_f(input logic stim, input logic invert);
    return stim ^ invert;
  endfunction

  assign resp_s       = resp_sync_q[SYNC_STAGES-1];
  assign start_s      = start_sync_q[SYNC_STAGES-1];
  assign start_edge_s = ena & start_s & ~start_prev_q;
  // stim_q is high exactly in RISE, so it doubles as the phase's stimulus level.
  assign match_s      = (resp_s == expected_f(stim_q, invert_q));
  assign timeout_s    = (cnt_q == TMO);
  assign unused_s     = &{1'b0, ui_in[7:4], uio_in};

  // Input synchronizers and start edge history.
  always_comb begin
    resp_sync_d  = {resp_sync_q[SYNC_STAGES-2:0], ui_in[0]};
    start_sync_d = {start_sync_q[SYNC_STAGES-2:0], ui_in[1]};
    start_prev_d = start_s;
  end

  // Next-state and measurement datapath.
  always_comb begin
    state_d      = state_q;
    invert_d     = invert_q;
    cnt_d        = cnt_q;
    rise_dly_d   = rise_dly_q;
    fall_dly_d   = fall_dly_q;
    pass_d       = pass_q;
    err_settle_d = err_settle_q;
    err_rise_d   = err_rise_q;
    err_fall_d   = err_fall_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_edge_s) begin
          state_d      = SETTLE;
          invert_d     = ui_in[2];
          cnt_d        = 8'd0;
          rise_dly_d   = 8'd0;
          fall_dly_d   = 8'd0;
          pass_d       = 1'b0;
          err_settle_d = 1'b0;
          err_rise_d   = 1'b0;
          err_fall_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      SETTLE: begin
        if (match_s) begin
          cnt_d   = 8'd0;
          state_d = RISE;
        end else if (timeout_s) begin
          err_settle_d = 1'b1;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RISE: begin
        if (match_s) begin
          rise_dly_d = cnt_q;
          cnt_d      = 8'd0;
          state_d    = FALL;
        end else if (timeout_s) begin
          rise_dly_d = TMO;
          err_rise_d = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      FALL: begin
        if (match_s) begin
          fall_dly_d = cnt_q;
          pass_d     = 1'b1;
          state_d    = DONE;
        end else if (timeout_s) begin
          fall_dly_d = TMO;
          err_fall_d = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered status outputs follow the state being entered.
  always_comb begin
    stim_d = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      SETTLE:  busy_d = 1'b1;
      RISE: begin
        busy_d = 1'b1;
        stim_d = 1'b1;
      end
      FALL:    busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      resp_sync_q  <= '0;
      start_sync_q <= '0;
      start_prev_q <= 1'b0;
      invert_q     <= 1'b0;
      cnt_q        <= 8'd0;
      rise_dly_q   <= 8'd0;
      fall_dly_q   <= 8'd0;
      pass_q       <= 1'b0;
      err_settle_q <= 1'b0;
      err_rise_q   <= 1'b0;
      err_fall_q   <= 1'b0;
      stim_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_sync_q  <= resp_sync_d;
      start_sync_q <= start_sync_d;
      start_prev_q <= start_prev_d;
      invert_q     <= invert_d;
      cnt_q        <= cnt_d;
      rise_dly_q   <= rise_dly_d;
      fall_dly_q   <= fall_dly_d;
      pass_q       <= pass_d;
      err_settle_q <= err_settle_d;
      err_rise_q   <= err_rise_d;
      err_fall_q   <= err_fall_d;
      stim_q       <= stim_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign uo_out  = {1'b0, err_fall_q, err_rise_q, err_settle_q, pass_q, done_q, busy_q, stim_q};
  assign uio_out = ui_in[3] ? fall_dly_q : rise_dly_q;
  assign uio_oe  = 8'hFF;

endmodule

// File: doc/tt_um_noritsuna_inv_probe.md
# tt_um_noritsuna_inv_probe

Digital stimulus-and-measure companion for the analog inverter tile. It drives the inverter input from a digital output pin and samples the inverter output on a digital input pin. It measures the response delay, in clock cycles, for a rising and a falling stimulus edge, then reports pass/fail and the delays on the dedicated and bidirectional pins. It occupies a standard TT user slot and connects to the analog inverter through board-level wiring.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles to wait for a response per phase (1..255).
- SYNC_STAGES, 2: synchronizer depth on ui_in[0] and ui_in[1] (≥2).

Ports:
- clk  input  1  system clock; only clock.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  start is accepted only when ena=1.
- ui_in  input  8  [0] inverter output sense; [1] start (level, rising edge detected after sync); [2] invert: 1 = DUT expected inverting; [3] report select (0 = rise delay, 1 = fall delay); [7:4] unused.
- uo_out  output  8  [0] stim (drives inverter input); [1] busy; [2] done; [3] pass; [4] err_settle; [5] err_rise; [6] err_fall; [7] 0.
- uio_in  input  8  unused.
- uio_out  output  8  selected delay (rise_dly or fall_dly per ui_in[3], combinational mux of registers).
- uio_oe  output  8  constant 8'hFF.

## Operation
- resp_s = ui_in[0] after SYNC_STAGES flops. start edge = rising edge of synchronized ui_in[1], gated by ena.
- expected(stim) = invert ? ~stim : stim. invert is sampled at the start edge and held for the run.
- FSM states: IDLE, SETTLE, RISE, FALL, DONE.
  - IDLE: stim=0. On start edge: clear pass, errors, rise_dly and fall_dly, cnt=0; go to SETTLE.
  - SETTLE: stim=0. When resp_s==expected(0), cnt=0, stim←1, go to RISE. If cnt reaches TIMEOUT first: err_settle=1, go to DONE.
  - RISE: stim=1. If resp_s==expected(1): rise_dly←cnt, cnt=0, stim←0, go to FALL. If cnt==TIMEOUT: rise_dly←TIMEOUT, err_rise=1, stim←0, go to DONE.
  - FALL: stim=0. Same rule with expected(0). Success: fall_dly←cnt, pass←1, go to DONE. Timeout: fall_dly←TIMEOUT, err_fall=1, go to DONE.
  - DONE: results held. A start edge behaves as in IDLE (restart → SETTLE).
- cnt is 8 bits and increments each cycle in SETTLE/RISE/FALL while there is no match. It never exceeds TIMEOUT.
- busy=1 in SETTLE/RISE/FALL. done=1 in DONE only.
- Start edges while busy are ignored. ena=0 blocks new starts but does not abort a run.
- Exactly one of pass/err_* is set in DONE.

## Timing
- All outputs are registered except uio_out (mux) and uio_oe (constant).
- Reset values: stim, busy, done, pass, err_*=0; rise_dly=fall_dly=0; cnt=0; state IDLE; uo_out=8'h00, uio_out=8'h00.
- Reset asserted mid-run: everything returns to reset values immediately, including stim=0.
- Start latency: SYNC_STAGES+1 cycles from the ui_in[1] rise to busy=1.
- Delay reference: stim toggles at edge E0 with cnt=0. Zero external delay reports delay = SYNC_STAGES (2 by default). An external delay of D whole cycles reports D+SYNC_STAGES.
- SETTLE and a successful phase end on the cycle the match is seen. A timeout phase ends on the cycle cnt==TIMEOUT.
- If match and cnt==TIMEOUT occur in the same cycle, the match wins (success, dly=TIMEOUT).

## Test plan
- Ideal inverting loopback (ui_in[0]=~uo_out[0]), invert=1, start → done=1, pass=1, rise_dly=fall_dly=2, errors 0; uio_out follows ui_in[3].
- Inverting loopback with 5-cycle delay model → rise_dly=fall_dly=7, pass=1.
- Non-inverting loopback with invert=1 → err_settle=1, pass=0, done after TIMEOUT cycles in SETTLE; stim never goes high.
- Response stuck at 1, invert=1 → settle OK, RISE times out: err_rise=1, rise_dly=255, stim=0 in DONE.
- Start pulse during RISE is ignored; ena=0 start is ignored. A start from DONE restarts and clears previous results.
- rst_n asserted in FALL → all outputs 0 asynchronously; a fresh run after release passes with the expected delays.
